// File: rtl/bus_pkg.sv
// Shared definitions for the bus scheduler: source/destination encodings,
// FSM state type and the source-to-select decoder.
package bus_pkg;

  localparam logic [2:0] SRC_R    = 3'd0;
  localparam logic [2:0] SRC_AR   = 3'd1;
  localparam logic [2:0] SRC_DR   = 3'd2;
  localparam logic [2:0] SRC_AC   = 3'd3;
  localparam logic [2:0] SRC_PC   = 3'd4;
  localparam logic [2:0] SRC_IR   = 3'd5;
  localparam logic [2:0] SRC_DRAM = 3'd6;
  localparam logic [2:0] SRC_IRAM = 3'd7;

  localparam int unsigned DST_R    = 0;
  localparam int unsigned DST_AR   = 1;
  localparam int unsigned DST_DR   = 2;
  localparam int unsigned DST_AC   = 3;
  localparam int unsigned DST_PC   = 4;
  localparam int unsigned DST_IR   = 5;
  localparam int unsigned DST_DRAM = 6;

  localparam int unsigned CMD_W = 10;  // {src[2:0], dst[6:0]}

  typedef enum logic [1:0] {StIdle, StSelect, StWait, StLoad} state_e;

  function automatic logic [7:0] src_to_onehot(input logic [2:0] src);
    src_to_onehot = 8'd1 << src;
  endfunction

endpackage

// File: rtl/bus_scheduler_if.sv
// Command handshake and bus-control signals between control unit and scheduler.
interface bus_scheduler_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_src;
  logic [6:0] cmd_dst;
  logic [5:0] control_register;
  logic [1:0] control_memory;
  logic       mem_read;
  logic [6:0] load_en;
  logic       done;
  logic       err;
  logic       busy;

  modport master (
    output cmd_valid, cmd_src, cmd_dst,
    input  cmd_ready, control_register, control_memory, mem_read, load_en, done, err, busy
  );

  modport slave (
    input  cmd_valid, cmd_src, cmd_dst,
    output cmd_ready, control_register, control_memory, mem_read, load_en, done, err, busy
  );
endinterface

// File: rtl/bus_cmd_fifo.sv
// Small synchronous command FIFO with first-word fall-through read data.
module bus_cmd_fifo
  import bus_pkg::*;
#(
  parameter int unsigned QDEPTH = 2,
  parameter int unsigned WIDTH  = CMD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(QDEPTH);

  logic [WIDTH-1:0] mem_q [QDEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/bus_scheduler.sv
// Sequences queued bus transfers: select source, optional memory wait states,
// then a one-cycle destination load strobe.
module bus_scheduler
  import bus_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned QDEPTH   = 2
) (
  input logic            clk,
  input logic            rst_n,
  bus_scheduler_if.slave bus
);

  localparam int unsigned CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      sel_q, sel_d;
  logic [6:0]      dst_q, dst_d;
  logic [6:0]      load_en_q, load_en_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            pop, start, full, empty;
  logic [CMD_W-1:0] head;

  bus_cmd_fifo #(
    .QDEPTH(QDEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (bus.cmd_valid),
    .wdata({bus.cmd_src, bus.cmd_dst}),
    .pop  (pop),
    .rdata(head),
    .full (full),
    .empty(empty)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    dst_d     = dst_q;
    load_en_d = '0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    pop       = 1'b0;
    start     = 1'b0;

    unique case (state_q)
      StIdle: start = ~empty;
      StSelect: begin
        if (sel_q[7:6] != 2'b00 && MEM_WAIT > 0) begin
          state_d = StWait;
          cnt_d   = CW'(MEM_WAIT - 1);
        end else begin
          state_d   = StLoad;
          load_en_d = dst_q;
          done_d    = 1'b1;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d   = StLoad;
          load_en_d = dst_q;
          done_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StLoad: begin
        if (!empty) begin
          start = 1'b1;
        end else begin
          state_d = StIdle;
          sel_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    // An empty destination mask is discarded with an error pulse.
    if (start) begin
      pop = 1'b1;
      if (head[6:0] == 7'd0) begin
        err_d   = 1'b1;
        state_d = StIdle;
        sel_d   = '0;
      end else begin
        state_d = StSelect;
        sel_d   = src_to_onehot(head[9:7]);
        dst_d   = head[6:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      sel_q     <= '0;
      dst_q     <= '0;
      load_en_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      dst_q     <= dst_d;
      load_en_q <= load_en_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.cmd_ready        = ~full;
  assign bus.control_register = sel_q[5:0];
  assign bus.control_memory   = sel_q[7:6];
  assign bus.mem_read         = |sel_q[7:6];
  assign bus.load_en          = load_en_q;
  assign bus.done             = done_q;
  assign bus.err              = err_q;
  assign bus.busy             = (state_q != StIdle) | ~empty;

endmodule

// File: tb/tb_bus_scheduler.sv
// Directed and random stimulus for bus_scheduler, checked every cycle against a
// transfer-duration reference model.
module tb_bus_scheduler;

  localparam int unsigned MW = 2;
  localparam int unsigned QD = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  bus_scheduler_if bif ();

  bus_scheduler #(
    .MEM_WAIT(MW),
    .QDEPTH  (QD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif)
  );

  always #5 clk = ~clk;

  // Model: a started transfer shows its select for a fixed number of cycles
  // (2 for registers, 2+MW for memory) and loads in the last of them.
  logic [9:0] mq[$];
  int         m_left;
  logic [7:0] m_sel;
  logic [6:0] m_dst, m_load;
  logic       m_done, m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_left = 0;
    m_sel  = '0;
    m_dst  = '0;
    m_load = '0;
    m_done = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic model_edge(input logic v, input logic [2:0] s, input logic [6:0] d);
    int         old_left;
    int         sz;
    logic [9:0] h;
    old_left = m_left;
    sz       = mq.size();
    m_load   = '0;
    m_done   = 1'b0;
    m_err    = 1'b0;
    m_left   = (old_left > 0) ? old_left - 1 : 0;
    if (m_left == 1) begin
      m_load = m_dst;
      m_done = 1'b1;
    end
    if (m_left == 0) m_sel = '0;
    if (old_left <= 1 && sz > 0) begin
      h = mq.pop_front();
      if (h[6:0] == 7'd0) begin
        m_err = 1'b1;
      end else begin
        m_sel  = 8'd1 << h[9:7];
        m_dst  = h[6:0];
        m_left = (h[9:7] >= 3'd6) ? 2 + MW : 2;
      end
    end
    if (v && sz < QD) mq.push_back({s, d});
  endtask

  task automatic check_all();
    chk("select", {bif.control_memory, bif.control_register}, m_sel);
    chk("load_en", bif.load_en, m_load);
    chk("done", bif.done, m_done);
    chk("err", bif.err, m_err);
    chk("mem_read", bif.mem_read, (m_sel[7:6] != 2'b00));
    chk("busy", bif.busy, (m_left > 0 || mq.size() > 0));
    chk("cmd_ready", bif.cmd_ready, (mq.size() < QD));
  endtask

  task automatic cycle(input logic v, input logic [2:0] s, input logic [6:0] d);
    bif.cmd_valid = v;
    bif.cmd_src   = s;
    bif.cmd_dst   = d;
    @(posedge clk);
    model_edge(v, s, d);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 7'd0);
  endtask

  initial begin
    bif.cmd_valid = 1'b0;
    bif.cmd_src   = '0;
    bif.cmd_dst   = '0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Register move ac -> dr
    cycle(1'b1, 3'd3, 7'b0000100);
    chk("move_e0_sel", bif.control_register, 6'b000000);
    cycle(1'b0, 3'd0, 7'd0);
    chk("move_e1_sel", bif.control_register, 6'b001000);
    chk("move_e1_load", bif.load_en, 7'b0000000);
    cycle(1'b0, 3'd0, 7'd0);
    chk("move_e2_load", bif.load_en, 7'b0000100);
    chk("move_e2_done", bif.done, 1'b1);
    idle(2);

    // Memory read from dram with two wait states
    cycle(1'b1, 3'd6, 7'b0000001);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 3'd0, 7'd0);
      chk("mem_sel", bif.control_memory, 2'b01);
      chk("mem_noload", bif.load_en, 7'd0);
    end
    cycle(1'b0, 3'd0, 7'd0);
    chk("mem_load", bif.load_en, 7'b0000001);
    idle(2);

    // Back-to-back register transfers fill the queue
    cycle(1'b1, 3'd0, 7'b0001000);
    cycle(1'b1, 3'd1, 7'b0010000);
    cycle(1'b1, 3'd5, 7'b0000010);
    chk("b2b_full", bif.cmd_ready, 1'b0);
    idle(8);

    // Empty destination mask is discarded; next command still runs
    cycle(1'b1, 3'd1, 7'd0);
    cycle(1'b1, 3'd2, 7'b0001000);
    chk("err_pulse", bif.err, 1'b1);
    chk("err_nosel", bif.control_register, 6'd0);
    idle(4);

    // Multi-destination from pc
    cycle(1'b1, 3'd4, 7'b0000011);
    cycle(1'b0, 3'd0, 7'd0);
    chk("multi_sel", bif.control_register, 6'b010000);
    cycle(1'b0, 3'd0, 7'd0);
    chk("multi_load", bif.load_en, 7'b0000011);
    idle(2);

    // Reset during LOAD with commands still queued
    cycle(1'b1, 3'd2, 7'b0100000);
    cycle(1'b1, 3'd0, 7'b0000010);
    cycle(1'b1, 3'd7, 7'b0000100);
    chk("pre_rst_load", bif.load_en, 7'b0100000);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [6:0] d;
      d = 7'($urandom_range(1, 127));
      if ($urandom_range(0, 7) == 0) d = 7'd0;
      cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), d);
    end
    idle(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
